// File: rtl/codec_config_sequencer.sv
// Sequencer that walks the WM8731 register table and hands each write to the I2C controller.
// Also produces the slow controller clock; all sequencing advances on its falling edge.
`timescale 1ns/1ps

module codec_config_sequencer #(
  parameter int unsigned CLK_DIV       = 1250,
  parameter int unsigned POWERUP_DELAY = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned END_TIMEOUT   = 40,
  parameter logic [7:0]  SLAVE_ADDR    = 8'h34
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic        END,
  input  logic        ACK,
  output logic        I2C_CTRL_CLK,
  output logic [23:0] I2C_DATA,
  output logic        GO,
  output logic [3:0]  LUT_INDEX,
  output logic        CONFIG_DONE,
  output logic        CONFIG_ERR
);

  localparam logic [3:0] LastIndex = 4'd9;

  typedef enum logic [2:0] {
    StPwrup, StLoad, StIssue, StWait, StCheck, StDone, StError
  } state_e;

  state_e      state_q;
  logic [15:0] div_q;
  logic [15:0] dly_q;
  logic [15:0] tmo_q;
  logic [7:0]  retry_q;
  logic        load_q;
  logic        armed_q;
  logic        tmo_fail_q;
  logic        start_pend_q;
  logic        tick;

  function automatic logic [15:0] lut(input logic [3:0] idx);
    case (idx)
      4'd0:    lut = 16'h1E00;
      4'd1:    lut = 16'h001A;
      4'd2:    lut = 16'h021A;
      4'd3:    lut = 16'h047B;
      4'd4:    lut = 16'h067B;
      4'd5:    lut = 16'h0812;
      4'd6:    lut = 16'h0A06;
      4'd7:    lut = 16'h0C00;
      4'd8:    lut = 16'h0E01;
      4'd9:    lut = 16'h1201;
      default: lut = 16'h0000;
    endcase
  endfunction

  // A tick is the system cycle in which the divided clock falls.
  assign tick = (div_q == 16'(CLK_DIV - 1)) && I2C_CTRL_CLK;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      div_q        <= '0;
      I2C_CTRL_CLK <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      if (div_q == 16'(CLK_DIV - 1)) begin
        div_q        <= '0;
        I2C_CTRL_CLK <= ~I2C_CTRL_CLK;
      end else begin
        div_q <= div_q + 16'd1;
      end
      // START is a system-rate pulse; hold it until the sequencer next looks.
      if (tick)       start_pend_q <= 1'b0;
      else if (START) start_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StPwrup;
      dly_q       <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      load_q      <= 1'b0;
      armed_q     <= 1'b0;
      tmo_fail_q  <= 1'b0;
      GO          <= 1'b0;
      I2C_DATA    <= '0;
      LUT_INDEX   <= '0;
      CONFIG_DONE <= 1'b0;
      CONFIG_ERR  <= 1'b0;
    end else if (tick) begin
      case (state_q)
        StPwrup: begin
          GO <= 1'b0;
          if (dly_q == 16'(POWERUP_DELAY - 1)) begin
            dly_q   <= '0;
            state_q <= StLoad;
          end else begin
            dly_q <= dly_q + 16'd1;
          end
        end
        StLoad: begin
          I2C_DATA <= {SLAVE_ADDR, lut(LUT_INDEX)};
          // Two ticks with GO low let the controller clear its counter first.
          if (load_q) begin
            load_q  <= 1'b0;
            GO      <= 1'b1;
            state_q <= StIssue;
          end else begin
            GO     <= 1'b0;
            load_q <= 1'b1;
          end
        end
        StIssue: begin
          armed_q    <= 1'b0;
          tmo_q      <= '0;
          tmo_fail_q <= 1'b0;
          state_q    <= StWait;
        end
        StWait: begin
          // END must be seen low first so the idle END=1 cannot complete a write.
          if (armed_q && END) begin
            GO      <= 1'b0;
            state_q <= StCheck;
          end else if (tmo_q == 16'(END_TIMEOUT - 1)) begin
            tmo_fail_q <= 1'b1;
            GO         <= 1'b0;
            state_q    <= StCheck;
          end else begin
            tmo_q <= tmo_q + 16'd1;
            if (!END) armed_q <= 1'b1;
          end
        end
        StCheck: begin
          GO <= 1'b0;
          if (!ACK && !tmo_fail_q) begin
            retry_q <= '0;
            if (LUT_INDEX == LastIndex) begin
              CONFIG_DONE <= 1'b1;
              state_q     <= StDone;
            end else begin
              LUT_INDEX <= LUT_INDEX + 4'd1;
              state_q   <= StLoad;
            end
          end else begin
            retry_q <= retry_q + 8'd1;
            if (retry_q == 8'(MAX_RETRY - 1)) begin
              CONFIG_ERR <= 1'b1;
              state_q    <= StError;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StDone, StError: begin
          GO <= 1'b0;
          if (start_pend_q || START) begin
            CONFIG_DONE <= 1'b0;
            CONFIG_ERR  <= 1'b0;
            LUT_INDEX   <= '0;
            retry_q     <= '0;
            state_q     <= StLoad;
          end
        end
        default: state_q <= StPwrup;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: an I2C controller model answers each GO, and a table-level
// model predicts which words are issued and how the run ends.
`timescale 1ns/1ps

module tb_codec_config_sequencer;

  localparam int unsigned CLK_DIV       = 4;
  localparam int unsigned POWERUP_DELAY = 16;
  localparam int unsigned MAX_RETRY     = 3;
  localparam int unsigned END_TIMEOUT   = 40;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        END   = 1'b1;
  logic        ACK   = 1'b0;
  logic        I2C_CTRL_CLK;
  logic [23:0] I2C_DATA;
  logic        GO;
  logic [3:0]  LUT_INDEX;
  logic        CONFIG_DONE;
  logic        CONFIG_ERR;

  always #5 CLOCK = ~CLOCK;

  codec_config_sequencer #(
    .CLK_DIV      (CLK_DIV),
    .POWERUP_DELAY(POWERUP_DELAY),
    .MAX_RETRY    (MAX_RETRY),
    .END_TIMEOUT  (END_TIMEOUT),
    .SLAVE_ADDR   (8'h34)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .START       (START),
    .END         (END),
    .ACK         (ACK),
    .I2C_CTRL_CLK(I2C_CTRL_CLK),
    .I2C_DATA    (I2C_DATA),
    .GO          (GO),
    .LUT_INDEX   (LUT_INDEX),
    .CONFIG_DONE (CONFIG_DONE),
    .CONFIG_ERR  (CONFIG_ERR)
  );

  logic [15:0] ref_tab [10] = '{16'h1E00, 16'h001A, 16'h021A, 16'h047B, 16'h067B,
                                16'h0812, 16'h0A06, 16'h0C00, 16'h0E01, 16'h1201};

  typedef struct {
    int nack_e; int nack_n; int hang_e; int hang_n;
    int exp_gos; int exp_done; int exp_err; int exp_idx;
  } vec_t;

  int vec = 0;
  int miscmp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: per-entry counts of NACKed and hung (END never returns) attempts.
  int   nack_left [10];
  int   hang_left [10];
  logic busy = 1'b0;
  logic hang_now;
  logic ack_now;
  int   lat;
  int   ccnt;

  function automatic int find_entry(input logic [15:0] w);
    for (int i = 0; i < 10; i++) if (ref_tab[i] == w) return i;
    return 0;
  endfunction

  always @(posedge I2C_CTRL_CLK or negedge RESET) begin
    int e;
    if (!RESET) begin
      END  <= 1'b1;
      ACK  <= 1'b0;
      busy <= 1'b0;
    end else if (!busy) begin
      if (GO) begin
        e = find_entry(I2C_DATA[15:0]);
        busy     <= 1'b1;
        END      <= 1'b0;
        ccnt     <= 1;
        lat      <= int'($urandom_range(3, 8));
        hang_now <= 1'b0;
        ack_now  <= 1'b0;
        if (hang_left[e] > 0) begin
          hang_left[e]--;
          hang_now <= 1'b1;
        end else if (nack_left[e] > 0) begin
          nack_left[e]--;
          ack_now <= 1'b1;
        end
      end
    end else if (!GO) begin
      busy <= 1'b0;
    end else if (!hang_now) begin
      ccnt <= ccnt + 1;
      if (ccnt + 1 == lat) begin
        END <= 1'b1;
        ACK <= ack_now;
      end
    end
  end

  // Monitor: counts ticks (falling edges of the divided clock) and logs every issued word.
  logic        prev_clk = 1'b0;
  logic        prev_go  = 1'b0;
  int          tick_cnt = 0;
  int          first_go_tick = -1;
  int          go_rise_t = 0;
  int          last_go_len = 0;
  logic [23:0] seen [$];

  always @(negedge CLOCK) begin
    if (!RESET) begin
      tick_cnt      = 0;
      first_go_tick = -1;
    end else if (prev_clk && !I2C_CTRL_CLK) begin
      tick_cnt++;
    end
    if (GO && !prev_go) begin
      seen.push_back(I2C_DATA);
      go_rise_t = tick_cnt;
      if (first_go_tick < 0) first_go_tick = tick_cnt;
    end
    if (!GO && prev_go) last_go_len = tick_cnt - go_rise_t;
    prev_clk = I2C_CTRL_CLK;
    prev_go  = GO;
  end

  task automatic step();
    @(negedge CLOCK);
    #1;
  endtask

  task automatic set_policy(input int ne, input int nn, input int he, input int hn);
    for (int i = 0; i < 10; i++) begin
      nack_left[i] = 0;
      hang_left[i] = 0;
    end
    if (ne >= 0) nack_left[ne] = nn;
    if (he >= 0) hang_left[he] = hn;
  endtask

  // Pulse START for one system cycle a few cycles after a tick, i.e. between ticks.
  task automatic pulse_start(output int t0);
    int t_prev;
    int guard;
    t_prev = tick_cnt;
    guard  = 0;
    while (tick_cnt == t_prev && guard < 40) begin
      step();
      guard++;
    end
    repeat ($urandom_range(2, 5)) step();
    t0    = tick_cnt;
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic run_case(input string tag, input bit restart, input vec_t v);
    logic [23:0] exp_q [$];
    int err_idx;
    int f;
    int t0;
    int guard;
    err_idx = -1;
    for (int e = 0; e < 10; e++) begin
      f = nack_left[e] + hang_left[e];
      if (f >= int'(MAX_RETRY)) begin
        for (int k = 0; k < int'(MAX_RETRY); k++) exp_q.push_back({8'h34, ref_tab[e]});
        err_idx = e;
        break;
      end
      for (int k = 0; k <= f; k++) exp_q.push_back({8'h34, ref_tab[e]});
    end
    seen.delete();
    if (restart) begin
      pulse_start(t0);
      guard = 0;
      while ((CONFIG_DONE || CONFIG_ERR) && guard < 40) begin
        step();
        guard++;
      end
      check({tag, " flags clear tick"}, tick_cnt, t0 + 1);
      check({tag, " restart index"}, LUT_INDEX, 0);
      guard = 0;
      while (!GO && guard < 40) begin
        step();
        guard++;
      end
      check({tag, " restart GO tick"}, tick_cnt, t0 + 3);
    end
    guard = 0;
    while (!(CONFIG_DONE || CONFIG_ERR) && guard < 20000) begin
      step();
      guard++;
    end
    check({tag, " finished in budget"}, guard < 20000, 1);
    check({tag, " GO count"}, seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < seen.size()) check($sformatf("%s word%0d", tag, i), seen[i], exp_q[i]);
    check({tag, " done"}, CONFIG_DONE, err_idx < 0);
    check({tag, " err"}, CONFIG_ERR, err_idx >= 0);
    check({tag, " index"}, LUT_INDEX, (err_idx < 0) ? 9 : err_idx);
    check({tag, " flags exclusive"}, CONFIG_DONE && CONFIG_ERR, 0);
    if (v.exp_gos >= 0) begin
      check({tag, " table GO count"}, seen.size(), v.exp_gos);
      check({tag, " table done"}, CONFIG_DONE, v.exp_done);
      check({tag, " table err"}, CONFIG_ERR, v.exp_err);
      check({tag, " table index"}, LUT_INDEX, v.exp_idx);
    end
    if (!restart) check({tag, " first GO tick"}, first_go_tick, POWERUP_DELAY + 2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " clk"}, I2C_CTRL_CLK, 0);
    check({tag, " GO"}, GO, 0);
    check({tag, " data"}, I2C_DATA, 0);
    check({tag, " index"}, LUT_INDEX, 0);
    check({tag, " done"}, CONFIG_DONE, 0);
    check({tag, " err"}, CONFIG_ERR, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [4];
    vec_t rv;
    vec_t clean;
    int   n;
    int   m;
    int   guard;
    int   t0;
    int   r;

    tbl[0] = '{-1, 0, -1, 0, 10, 1, 0, 9};
    tbl[1] = '{3, 1, -1, 0, 11, 1, 0, 9};
    tbl[2] = '{5, 99, -1, 0, 8, 0, 1, 5};
    tbl[3] = '{-1, 0, 0, 99, 3, 0, 1, 0};
    clean  = '{-1, 0, -1, 0, 10, 1, 0, 9};

    set_policy(-1, 0, -1, 0);
    repeat (5) step();
    check_reset_outputs("reset");
    RESET = 1'b1;

    guard = 0;
    while (!I2C_CTRL_CLK && guard < 100) begin
      step();
      guard++;
    end
    n = 0;
    while (I2C_CTRL_CLK && n < 100) begin
      step();
      n++;
    end
    m = 0;
    while (!I2C_CTRL_CLK && m < 100) begin
      step();
      m++;
    end
    check("clk high cycles", n, CLK_DIV);
    check("clk period", n + m, 2 * CLK_DIV);

    for (int i = 0; i < 4; i++) begin
      set_policy(tbl[i].nack_e, tbl[i].nack_n, tbl[i].hang_e, tbl[i].hang_n);
      run_case($sformatf("vec%0d", i), i != 0, tbl[i]);
      if (tbl[i].hang_n > 0) check("timeout GO width", last_go_len, END_TIMEOUT + 1);
    end

    for (int s = 0; s < 6; s++) begin
      rv = '{-1, 0, -1, 0, -1, 0, 0, 0};
      set_policy(-1, 0, -1, 0);
      for (int e = 0; e < 10; e++) begin
        r = int'($urandom_range(0, 39));
        if (r >= 28 && r < 34)      nack_left[e] = 1;
        else if (r >= 34 && r < 37) nack_left[e] = 2;
        else if (r == 37)           nack_left[e] = 5;
        else if (r == 38)           hang_left[e] = 1;
      end
      run_case($sformatf("rand%0d", s), 1'b1, rv);
    end

    // Reset in the middle of entry 4's transfer.
    set_policy(-1, 0, -1, 0);
    pulse_start(t0);
    guard = 0;
    while (!(GO && LUT_INDEX == 4) && guard < 5000) begin
      step();
      guard++;
    end
    check("reached entry 4 wait", guard < 5000, 1);
    repeat (3) step();
    #2 RESET = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (6) step();
    RESET = 1'b1;
    run_case("after reset", 1'b0, clean);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
- Upstream stage of the codec I2C controller.
- Walks a fixed table of WM8731 register writes and presents each one as a 24-bit word {slave addr, sub addr, data} with a GO/END handshake.
- Checks the controller's ACK, retries NACKed writes and reports completion or error.
- Also generates the slow clock that drives the I2C controller, derived from the system clock with a registered divider.

Parameters:
- CLK_DIV, 1250: system-clock cycles per half period of I2C_CTRL_CLK (50 MHz gives 20 kHz).
- POWERUP_DELAY, 16: ticks to wait after reset before the first transfer.
- MAX_RETRY, 3: attempts per register before flagging an error.
- END_TIMEOUT, 40: ticks allowed between GO=1 and END=1.
- SLAVE_ADDR, 8'h34: I2C write address placed in I2C_DATA[23:16].

Ports:
- CLOCK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  synchronous pulse; restarts the full configuration from entry 0 when in DONE or ERROR.
- END  in  1  from the I2C controller; 1 = transfer finished or idle.
- ACK  in  1  from the I2C controller; OR of the three ack slots, 0 = all acknowledged.
- I2C_CTRL_CLK  out  1  registered divided clock feeding the controller's CLOCK input.
- I2C_DATA  out  24  {SLAVE_ADDR, 7-bit reg addr, 9-bit data}.
- GO  out  1  transfer request to the controller.
- LUT_INDEX  out  4  current table entry, 0..9.
- CONFIG_DONE  out  1  high once all entries were written and acknowledged.
- CONFIG_ERR  out  1  high when an entry failed MAX_RETRY times.

Behaviour:
- Reset values: I2C_CTRL_CLK=0, GO=0, I2C_DATA=0, LUT_INDEX=0, CONFIG_DONE=0, CONFIG_ERR=0; state PWRUP; divider, retry and timeout counters=0.
- Divider:
  - 16-bit counter counts 0..CLK_DIV-1; I2C_CTRL_CLK toggles at wrap.
  - "tick" = the system cycle in which I2C_CTRL_CLK toggles 1->0.
  - The FSM, GO, I2C_DATA, END/ACK sampling and all counters other than the divider update only on ticks. Outputs are therefore stable half a period before each controller rising edge.
- Table, 10 entries, {reg[6:0], data[8:0]} as 16 bits:
  - 0: 1E00 (reset)
  - 1: 001A
  - 2: 021A
  - 3: 047B
  - 4: 067B
  - 5: 0812 (DAC select)
  - 6: 0A06
  - 7: 0C00 (power up)
  - 8: 0E01 (left-justified 16 bit)
  - 9: 1201 (active, must be last)
- FSM states:
  - PWRUP: count POWERUP_DELAY ticks with GO=0, then go to LOAD.
  - LOAD: I2C_DATA={SLAVE_ADDR, table[LUT_INDEX]}; GO=0; stay 2 ticks so the controller clears its counter and END drops; then go to ISSUE.
  - ISSUE: GO=1; clear the armed flag and the timeout counter; go to WAIT.
  - WAIT:
    - END=0 sampled sets armed.
    - armed and END=1 goes to CHECK.
    - Timeout counter reaching END_TIMEOUT counts as a failure and goes to CHECK with the failure forced.
  - CHECK:
    - GO=0.
    - If ACK=0 and no timeout: retry=0. If LUT_INDEX=9 go to DONE; otherwise LUT_INDEX+1 and go to LOAD.
    - Otherwise retry+1. If retry reaches MAX_RETRY go to ERROR; else go to LOAD with the same index.
  - DONE: CONFIG_DONE=1, GO=0.
  - ERROR: CONFIG_ERR=1, GO=0, LUT_INDEX holds the failing entry.
- START sampled in DONE or ERROR:
  - Clears the flags, LUT_INDEX and retry; goes to LOAD, with no power-up delay.
  - START is ignored in all other states.
  - START is captured at system rate and held pending until the next tick.
- END is ignored while not in WAIT; the post-reset END=1 does not complete a transfer because armed is required.
- RESET asserted mid-transfer returns everything to reset values immediately. GO=0 at the next tick guarantees the controller aborts and releases SDA via its own reset.
- CONFIG_DONE and CONFIG_ERR are mutually exclusive and never both high.

Test Plan:
- Reset, CLK_DIV=4, controller model always acks:
  - I2C_CTRL_CLK period is 8 cycles.
  - First GO rises 16+2 ticks after reset release.
  - I2C_DATA sequence is 341E00, 34001A, … 341201.
  - CONFIG_DONE=1 after the 10th END.
  - Exactly 10 GO pulses.
- Model NACKs entry 3 once:
  - Entry 3 (34047B) is issued twice, then sequencing continues.
  - CONFIG_DONE=1, CONFIG_ERR=0, 11 GO pulses total.
- Model NACKs entry 5 always:
  - 3 attempts, then CONFIG_ERR=1 with LUT_INDEX=5.
  - Entries 6..9 are never issued.
- Model never raises END:
  - After 40 ticks in WAIT each attempt fails.
  - Three attempts, then CONFIG_ERR=1 at LUT_INDEX=0.
- After ERROR, pulse START for 1 system cycle mid-tick:
  - Restart happens at the next tick from entry 0.
  - No power-up delay; flags clear.
- Assert RESET during entry 4's WAIT:
  - All outputs return to reset values immediately.
  - After release the sequence restarts at entry 0 after POWERUP_DELAY.
